// File: rtl/io_port_hub.sv
// I/O port hub: an input port mux with a stream FIFO on port 0, plus strobed output registers.
// Define IO_PORT_HUB_ITR_EN to get a one-cycle itr pulse when the FIFO leaves the empty state.
module io_port_hub #(
  parameter int NUBITS = 16,
  parameter int NBIOIN = 2,
  parameter int NBIOOU = 2,
  parameter int FDEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [NUBITS-1:0]                io_in,
  input  logic [NBIOIN-1:0]                addr_in,
  input  logic                             req_in,
  input  logic [NUBITS-1:0]                io_out,
  input  logic [NBIOOU-1:0]                addr_out,
  input  logic                             out_en,
  output logic                             itr,
  input  logic [NUBITS-1:0]                s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [NUBITS*(2**NBIOIN)-1:0]    ext_in,
  output logic [NUBITS*(2**NBIOOU)-1:0]    ext_out,
  output logic [(2**NBIOOU)-1:0]           ext_stb,
  output logic                             underflow,
  input  logic                             uf_clr
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  logic [NUBITS-1:0] mem [FDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              empty;
  logic              rd_port0;
  logic              push;
  logic              pop;

  assign empty    = (count == '0);
  assign s_ready  = (count < CW'(FDEPTH));
  assign rd_port0 = req_in && (addr_in == '0);
  assign push     = s_valid && s_ready;
  assign pop      = rd_port0 && !empty;

  // Stream FIFO storage is data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Reading an empty FIFO sets the flag; a set outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     underflow <= 1'b0;
    else if (rd_port0 && empty)  underflow <= 1'b1;
    else if (uf_clr)             underflow <= 1'b0;
  end

  always_comb begin
    io_in = ext_in[int'(addr_in)*NUBITS +: NUBITS];
    if (addr_in == '0) io_in = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_out <= '0;
      ext_stb <= '0;
    end else begin
      ext_stb <= '0;
      if (out_en) begin
        ext_stb[addr_out]                           <= 1'b1;
        ext_out[int'(addr_out)*NUBITS +: NUBITS]    <= io_out;
      end
    end
  end

`ifdef IO_PORT_HUB_ITR_EN
  // While empty a pop is ignored, so any accepted push takes count from 0 to nonzero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) itr <= 1'b0;
    else     itr <= empty && push;
  end
`else
  assign itr = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_hub.sv
// Scoreboard bench for io_port_hub: a queue/array reference model predicts reads and per-cycle status.
module tb_io_port_hub;
  localparam int NUBITS = 16;
  localparam int NBIOIN = 2;
  localparam int NBIOOU = 2;
  localparam int FDEPTH = 4;
  localparam int NIN    = 2**NBIOIN;
  localparam int NOUT   = 2**NBIOOU;
`ifdef IO_PORT_HUB_ITR_EN
  localparam bit ITR = 1'b1;
`else
  localparam bit ITR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUBITS-1:0]        io_in;
  logic [NBIOIN-1:0]        addr_in = '0;
  logic                     req_in = 1'b0;
  logic [NUBITS-1:0]        io_out = '0;
  logic [NBIOOU-1:0]        addr_out = '0;
  logic                     out_en = 1'b0;
  logic                     itr;
  logic [NUBITS-1:0]        s_data = '0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [NUBITS*NIN-1:0]    ext_in = '0;
  logic [NUBITS*NOUT-1:0]   ext_out;
  logic [NOUT-1:0]          ext_stb;
  logic                     underflow;
  logic                     uf_clr = 1'b0;

  io_port_hub #(.NUBITS(NUBITS), .NBIOIN(NBIOIN), .NBIOOU(NBIOOU), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
    .io_out(io_out), .addr_out(addr_out), .out_en(out_en), .itr(itr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ext_in(ext_in),
    .ext_out(ext_out), .ext_stb(ext_stb), .underflow(underflow), .uf_clr(uf_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                     due;
    bit                     rdy;
    bit                     uf;
    bit                     it;
    logic [NUBITS*NOUT-1:0] eo;
    logic [NOUT-1:0]        stb;
  } st_t;

  typedef struct {
    int                due;
    logic [NUBITS-1:0] val;
  } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];

  // Reference model: FIFO as a queue, output ports as an array.
  logic [NUBITS-1:0] m_fifo[$];
  bit                m_uf;
  logic [NUBITS-1:0] m_eo [NOUT];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic st_t snap(input int due, input bit it, input logic [NOUT-1:0] stb);
    st_t s;
    s.due = due;
    s.rdy = (m_fifo.size() < FDEPTH);
    s.uf  = m_uf;
    s.it  = it;
    s.stb = stb;
    for (int k = 0; k < NOUT; k++) s.eo[k*NUBITS +: NUBITS] = m_eo[k];
    return s;
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    m_uf = 1'b0;
    for (int k = 0; k < NOUT; k++) m_eo[k] = '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input bit r, input bit sv, input logic [NUBITS-1:0] sd,
                      input bit rq, input int ai, input bit oe, input int ao,
                      input logic [NUBITS-1:0] od, input bit uc);
    int              pre;
    logic [NOUT-1:0] stb;
    bit              it;
    rd_t             re;
    @(posedge clk);
    #1;
    rst      = r;
    s_valid  = sv;
    s_data   = sd;
    req_in   = rq;
    addr_in  = NBIOIN'(ai);
    out_en   = oe;
    addr_out = NBIOOU'(ao);
    io_out   = od;
    uf_clr   = uc;
    ext_in   = {$urandom, $urandom};
    if (r) begin
      m_reset();
      if (st_q.size() > 0 && st_q[$].due == cyc) void'(st_q.pop_back());
      st_q.push_back(snap(cyc, 1'b0, '0));
      st_q.push_back(snap(cyc + 1, 1'b0, '0));
    end else begin
      pre = m_fifo.size();
      stb = '0;
      if (rq) begin
        re.due = cyc;
        if (ai != 0)     re.val = ext_in[ai*NUBITS +: NUBITS];
        else if (pre > 0) re.val = m_fifo[0];
        else             re.val = '0;
        rd_q.push_back(re);
      end
      if (rq && ai == 0 && pre > 0) void'(m_fifo.pop_front());
      if (rq && ai == 0 && pre == 0) m_uf = 1'b1;
      else if (uc)                   m_uf = 1'b0;
      if (sv && pre < FDEPTH) m_fifo.push_back(sd);
      if (oe) begin
        m_eo[ao] = od;
        stb[ao]  = 1'b1;
      end
      it = ITR && (pre == 0) && (m_fifo.size() > 0);
      st_q.push_back(snap(cyc + 1, it, stb));
    end
  endtask

  task automatic idle();
    tick(0, 0, '0, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic push(input logic [NUBITS-1:0] d);
    tick(0, 1, d, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic rd0();
    tick(0, 0, '0, 1, 0, 0, 0, '0, 0);
  endtask
  task automatic reset_n(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, '0, 0, 0, 0, 0, '0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    rd_t e;
    st_t s;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      chk("io_in", 64'(io_in), 64'(e.val));
    end
    if (st_q.size() > 0 && st_q[0].due == cyc) begin
      s = st_q.pop_front();
      chk("s_ready",   64'(s_ready),   64'(s.rdy));
      chk("underflow", 64'(underflow), 64'(s.uf));
      chk("itr",       64'(itr),       64'(s.it));
      chk("ext_out",   64'(ext_out),   64'(s.eo));
      chk("ext_stb",   64'(ext_stb),   64'(s.stb));
    end
  end

  initial begin
    m_reset();
    reset_n(3);
    idle();

    // Three pushes, three ordered reads, then an empty read
    push(16'h1111); push(16'h2222); push(16'h3333);
    rd0(); rd0(); rd0(); rd0();
    tick(0, 0, '0, 0, 0, 0, 0, '0, 1);
    idle();

    // Overfill: fifth word held until a pop frees a slot
    push(16'h0A01); push(16'h0A02); push(16'h0A03); push(16'h0A04);
    push(16'h0A05);
    tick(0, 1, 16'h0A05, 1, 0, 0, 0, '0, 0);
    push(16'h0A05);
    rd0(); rd0(); rd0(); rd0(); rd0();
    tick(0, 0, '0, 0, 0, 0, 0, '0, 1);

    // Output write and back-to-back strobes
    tick(0, 0, '0, 0, 0, 1, 2, 16'hBEEF, 0);
    idle();
    tick(0, 0, '0, 0, 0, 1, 1, 16'h1234, 0);
    tick(0, 0, '0, 0, 0, 1, 3, 16'h5678, 0);
    tick(0, 0, '0, 1, 2, 1, 0, 16'h9ABC, 0);
    idle();

    // Push and pop on an empty FIFO in the same cycle
    tick(0, 1, 16'hA5A5, 1, 0, 0, 0, '0, 0);
    rd0();
    tick(0, 0, '0, 0, 0, 0, 0, '0, 1);

    // Second push into a non-empty FIFO gives no interrupt
    push(16'h0B01); push(16'h0B02);
    rd0(); rd0();

    // Reset mid-stream
    push(16'h0C01); push(16'h0C02); push(16'h0C03);
    tick(1, 1, 16'h0C04, 0, 0, 1, 1, 16'hFFFF, 0);
    reset_n(1);
    rd0();
    tick(0, 0, '0, 1, 1, 0, 0, '0, 1);

    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(99) == 0), ($urandom_range(1) == 1), NUBITS'($urandom),
           ($urandom_range(1) == 1), int'($urandom_range(NIN - 1)),
           ($urandom_range(9) < 3), int'($urandom_range(NOUT - 1)),
           NUBITS'($urandom), ($urandom_range(9) == 0));
    end
    idle();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_cmp++;
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", st_q.size() + rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_port_hub.md
IO_PORT_HUB -- requirements
Module: io_port_hub

Interface
REQ-001 Parameter NUBITS, default 16, processor word width.
REQ-002 Parameter NBIOIN, default 2, input-port address bits; NIN = 2**NBIOIN ports.
REQ-003 Parameter NBIOOU, default 2, output-port address bits; NOUT = 2**NBIOOU ports.
REQ-004 Parameter FDEPTH, default 4, stream FIFO depth (power of two, >=2).
REQ-005 One clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-006 io_in  output  NUBITS  read data to processor.
REQ-007 addr_in  input  NBIOIN  processor input-port address.
REQ-008 req_in  input  1  processor input-read request.
REQ-009 io_out  input  NUBITS  processor write data.
REQ-010 addr_out  input  NBIOOU  processor output-port address.
REQ-011 out_en  input  1  processor write strobe.
REQ-012 itr  output  1  interrupt to processor.
REQ-013 s_data  input  NUBITS  external stream data into port 0 FIFO.
REQ-014 s_valid  input  1 / s_ready  output  1  stream valid/ready handshake.
REQ-015 ext_in  input  NUBITS*NIN  static inputs; slice k drives port k, k>=1 (slice 0 unused).
REQ-016 ext_out  output  NUBITS*NOUT  output registers; slice k = port k.
REQ-017 ext_stb  output  NOUT  one-cycle write pulse per output port.
REQ-018 underflow  output  1  sticky empty-read flag; uf_clr  input  1  clears it.

Function
REQ-019 io_in SHALL be combinational: FIFO head when addr_in=0 and FIFO non-empty, 0 when addr_in=0 and empty, ext_in slice addr_in otherwise.
REQ-020 Pop SHALL occur at the rising edge where req_in=1, addr_in=0, FIFO non-empty; req_in to other addresses SHALL have no side effect.
REQ-021 s_ready SHALL equal (count < FDEPTH); push SHALL occur at the edge where s_valid=1 and s_ready=1.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; when empty, pop SHALL be ignored, the push SHALL be stored and underflow SHALL be set.
REQ-023 req_in=1, addr_in=0, empty SHALL set underflow at that edge; uf_clr SHALL clear it; set wins over simultaneous clear.
REQ-024 Read/write pointers SHALL wrap modulo FDEPTH; count SHALL range 0..FDEPTH using clog2(FDEPTH)+1 bits.
REQ-025 out_en=1 SHALL load io_out into ext_out slice addr_out at that edge and assert ext_stb[addr_out] for exactly the following cycle; other slices hold.
REQ-026 Back-to-back out_en SHALL produce back-to-back strobes, latency one cycle, no loss.
REQ-027 Input and output paths SHALL be independent; same-cycle req_in and out_en SHALL both take effect.

Reset
REQ-028 While rst=1: FIFO empty (count=0, pointers 0), s_ready=1, ext_out all 0, ext_stb 0, underflow 0, itr 0.
REQ-029 Reset mid-transfer SHALL discard FIFO contents; a push or pop coincident with reset deassertion edge SHALL not occur until the first edge with rst=0.

Configuration
REQ-030 Macro IO_PORT_HUB_ITR_EN: when defined, itr SHALL pulse high for one cycle after the edge at which count goes 0 -> nonzero; when undefined, itr SHALL be constant 0 and no itr logic SHALL be synthesized.

Verification
REQ-031 Reset, then push 0x1111, 0x2222, 0x3333 -> count 3; reads at addr 0 return 0x1111, 0x2222, 0x3333 in order, then 0 with underflow=1.
REQ-032 Push 5 words with FDEPTH=4 and no reads -> s_ready=0 after 4th push, 5th held; one pop -> 5th accepted next edge, order preserved.
REQ-033 out_en with addr_out=2, io_out=0xBEEF -> ext_out slice 2 = 0xBEEF, ext_stb=4'b0100 for one cycle; others unchanged.
REQ-034 Empty FIFO, same-cycle push 0xA5A5 and pop -> underflow=1, count=1, next read returns 0xA5A5; uf_clr -> underflow=0.
REQ-035 With IO_PORT_HUB_ITR_EN: first push into empty FIFO -> itr=1 for exactly one cycle; second push -> no pulse; without macro itr stays 0.
REQ-036 Fill FIFO with 3 words, assert rst mid-stream -> count 0, ext_out 0, s_ready 1; subsequent read at addr 0 returns 0.
